// File: rtl/axil_rr_arbiter_if.sv
// axil_rr_arbiter_if: one AXI4-Lite link (AW, W, B, AR, R channels).
// master modport drives AW/W/AR and the B/R readies; slave modport the rest.
interface axil_rr_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                awvalid;
   logic [ADDR_W-1:0]   awaddr;
   logic                awready;
   logic                wvalid;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wready;
   logic                bvalid;
   logic [1:0]          bresp;
   logic                bready;
   logic                arvalid;
   logic [ADDR_W-1:0]   araddr;
   logic                arready;
   logic                rvalid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rready;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready,
      input  rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready,
      output rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: 2-master -> 1-slave AXI4-Lite round-robin arbiter.
// Ports: ACLK, ARESETn (sync, low), m0/m1 (slave modport), s (master
// modport), grant (owning master), busy (not IDLE).
module axil_rr_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   axil_rr_arbiter_if.slave  m0,
   axil_rr_arbiter_if.slave  m1,
   axil_rr_arbiter_if.master s,
   output logic              grant,
   output logic              busy
);
   typedef enum logic [2:0] {
      IDLE, WADDR, WRESP, RADDR, RDATA
   } state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;
   logic   pri_q, pri_d;
   logic   aw_done_q, aw_done_d;
   logic   w_done_q, w_done_d;

   logic [1:0] wreq, req;
   assign wreq = {m1.awvalid & m1.wvalid, m0.awvalid & m0.wvalid};
   assign req  = wreq | {m1.arvalid, m0.arvalid};

   logic st_waddr, st_wresp, st_raddr, st_rdata;
   assign st_waddr = (state_q == WADDR);
   assign st_wresp = (state_q == WRESP);
   assign st_raddr = (state_q == RADDR);
   assign st_rdata = (state_q == RDATA);

   logic sel_awvalid, sel_wvalid, sel_bready;
   logic sel_arvalid, sel_rready;
   assign sel_awvalid = grant_q ? m1.awvalid : m0.awvalid;
   assign sel_wvalid  = grant_q ? m1.wvalid  : m0.wvalid;
   assign sel_bready  = grant_q ? m1.bready  : m0.bready;
   assign sel_arvalid = grant_q ? m1.arvalid : m0.arvalid;
   assign sel_rready  = grant_q ? m1.rready  : m0.rready;

   logic [ADDR_W-1:0]   sel_awaddr, sel_araddr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W/8-1:0] sel_wstrb;
   assign sel_awaddr = grant_q ? m1.awaddr : m0.awaddr;
   assign sel_araddr = grant_q ? m1.araddr : m0.araddr;
   assign sel_wdata  = grant_q ? m1.wdata  : m0.wdata;
   assign sel_wstrb  = grant_q ? m1.wstrb  : m0.wstrb;

   // Gating every valid/ready with ARESETn makes them drop in the
   // same cycle reset is asserted, ahead of the synchronous state reset.
   assign s.awvalid = ARESETn & st_waddr & ~aw_done_q & sel_awvalid;
   assign s.wvalid  = ARESETn & st_waddr & ~w_done_q & sel_wvalid;
   assign s.bready  = ARESETn & st_wresp & sel_bready;
   assign s.arvalid = ARESETn & st_raddr & sel_arvalid;
   assign s.rready  = ARESETn & st_rdata & sel_rready;
   assign s.awaddr  = sel_awaddr;
   assign s.araddr  = sel_araddr;
   assign s.wdata   = sel_wdata;
   assign s.wstrb   = sel_wstrb;

   // Readies stay masked once a channel's beat has gone through, so a
   // master never sees a second handshake on a channel already done.
   logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
   assign aw_rdy = st_waddr & ~aw_done_q & s.awready;
   assign w_rdy  = st_waddr & ~w_done_q & s.wready;
   assign b_vld  = st_wresp & s.bvalid;
   assign ar_rdy = st_raddr & s.arready;
   assign r_vld  = st_rdata & s.rvalid;

   logic own0, own1;
   assign own0 = ARESETn & ~grant_q;
   assign own1 = ARESETn & grant_q;

   assign m0.awready = own0 & aw_rdy;
   assign m0.wready  = own0 & w_rdy;
   assign m0.bvalid  = own0 & b_vld;
   assign m0.arready = own0 & ar_rdy;
   assign m0.rvalid  = own0 & r_vld;
   assign m1.awready = own1 & aw_rdy;
   assign m1.wready  = own1 & w_rdy;
   assign m1.bvalid  = own1 & b_vld;
   assign m1.arready = own1 & ar_rdy;
   assign m1.rvalid  = own1 & r_vld;

   assign m0.bresp = s.bresp;
   assign m1.bresp = s.bresp;
   assign m0.rdata = s.rdata;
   assign m1.rdata = s.rdata;
   assign m0.rresp = s.rresp;
   assign m1.rresp = s.rresp;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign aw_hs = s.awvalid & s.awready;
   assign w_hs  = s.wvalid & s.wready;
   assign b_hs  = s.bvalid & s.bready;
   assign ar_hs = s.arvalid & s.arready;
   assign r_hs  = s.rvalid & s.rready;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      pri_d     = pri_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = req[pri_q] ? pri_q : ~pri_q;
               state_d = wreq[grant_d] ? WADDR : RADDR;
            end
         end
         WADDR: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d & w_done_d) state_d = WRESP;
         end
         WRESP: begin
            if (b_hs) begin
               state_d   = IDLE;
               pri_d     = ~grant_q;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         RADDR: begin
            if (ar_hs) state_d = RDATA;
         end
         RDATA: begin
            if (r_hs) begin
               state_d = IDLE;
               pri_d   = ~grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         pri_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         pri_q     <= pri_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb_axil_rr_arbiter: two master drivers, a behavioural slave and an
// ordered scoreboard of expected B/R completions for axil_rr_arbiter.
module tb_axil_rr_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   logic grant, busy;
   always #5 ACLK = ~ACLK;

   axil_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
   axil_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
   axil_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

   axil_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .m0(m0_if), .m1(m1_if), .s(s_if),
      .grant(grant), .busy(busy)
   );

   logic            m_awvalid [2];
   logic [AW-1:0]   m_awaddr  [2];
   logic            m_wvalid  [2];
   logic [DW-1:0]   m_wdata   [2];
   logic [DW/8-1:0] m_wstrb   [2];
   logic            m_bready  [2];
   logic            m_arvalid [2];
   logic [AW-1:0]   m_araddr  [2];
   logic            m_rready  [2];

   assign m0_if.awvalid = m_awvalid[0];
   assign m0_if.awaddr  = m_awaddr[0];
   assign m0_if.wvalid  = m_wvalid[0];
   assign m0_if.wdata   = m_wdata[0];
   assign m0_if.wstrb   = m_wstrb[0];
   assign m0_if.bready  = m_bready[0];
   assign m0_if.arvalid = m_arvalid[0];
   assign m0_if.araddr  = m_araddr[0];
   assign m0_if.rready  = m_rready[0];
   assign m1_if.awvalid = m_awvalid[1];
   assign m1_if.awaddr  = m_awaddr[1];
   assign m1_if.wvalid  = m_wvalid[1];
   assign m1_if.wdata   = m_wdata[1];
   assign m1_if.wstrb   = m_wstrb[1];
   assign m1_if.bready  = m_bready[1];
   assign m1_if.arvalid = m_arvalid[1];
   assign m1_if.araddr  = m_araddr[1];
   assign m1_if.rready  = m_rready[1];

   logic          o_awready [2];
   logic          o_wready  [2];
   logic          o_bvalid  [2];
   logic [1:0]    o_bresp   [2];
   logic          o_arready [2];
   logic          o_rvalid  [2];
   logic [DW-1:0] o_rdata   [2];
   logic [1:0]    o_rresp   [2];

   assign o_awready[0] = m0_if.awready;
   assign o_wready[0]  = m0_if.wready;
   assign o_bvalid[0]  = m0_if.bvalid;
   assign o_bresp[0]   = m0_if.bresp;
   assign o_arready[0] = m0_if.arready;
   assign o_rvalid[0]  = m0_if.rvalid;
   assign o_rdata[0]   = m0_if.rdata;
   assign o_rresp[0]   = m0_if.rresp;
   assign o_awready[1] = m1_if.awready;
   assign o_wready[1]  = m1_if.wready;
   assign o_bvalid[1]  = m1_if.bvalid;
   assign o_bresp[1]   = m1_if.bresp;
   assign o_arready[1] = m1_if.arready;
   assign o_rvalid[1]  = m1_if.rvalid;
   assign o_rdata[1]   = m1_if.rdata;
   assign o_rresp[1]   = m1_if.rresp;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
      return a ^ 32'h1234_5658;
   endfunction

   typedef struct {
      logic            mst;
      logic            wr;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic [DW/8-1:0] strb;
   } exp_t;

   exp_t sb[$];
   logic exp_pri;

   // Behavioural slave
   logic [AW-1:0]   cap_awaddr;
   logic [DW-1:0]   cap_wdata;
   logic [DW/8-1:0] cap_wstrb;
   bit w_dly = 0;
   int r_dly = 0;

   initial begin : slave
      logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s;
      logic got_aw, got_w, rpend;
      logic [AW-1:0] ar_a;
      int wcnt, rcnt;
      s_if.awready = 1'b1; s_if.wready = 1'b1;
      s_if.bvalid = 1'b0;  s_if.bresp = 2'b00;
      s_if.arready = 1'b1; s_if.rvalid = 1'b0;
      s_if.rdata = '0;     s_if.rresp = 2'b00;
      got_aw = 0; got_w = 0; rpend = 0;
      wcnt = 0; rcnt = 0; ar_a = '0;
      forever begin
         @(negedge ACLK);
         rst_s = ARESETn;
         aw_hs = s_if.awvalid & s_if.awready;
         w_hs  = s_if.wvalid & s_if.wready;
         b_hs  = s_if.bvalid & s_if.bready;
         ar_hs = s_if.arvalid & s_if.arready;
         r_hs  = s_if.rvalid & s_if.rready;
         if (aw_hs) cap_awaddr = s_if.awaddr;
         if (w_hs) begin
            cap_wdata = s_if.wdata;
            cap_wstrb = s_if.wstrb;
         end
         if (ar_hs) ar_a = s_if.araddr;
         @(posedge ACLK);
         #1;
         if (!rst_s) begin
            got_aw = 0; got_w = 0; rpend = 0;
            wcnt = 0; rcnt = 0;
            s_if.bvalid = 1'b0;
            s_if.rvalid = 1'b0;
            s_if.wready = !w_dly;
         end else begin
            if (b_hs) s_if.bvalid = 1'b0;
            if (aw_hs) begin got_aw = 1; wcnt = 3; end
            else if (wcnt > 0) wcnt--;
            if (w_hs) got_w = 1;
            if (got_aw && got_w) begin
               s_if.bvalid = 1'b1;
               got_aw = 0; got_w = 0;
            end
            s_if.wready = !w_dly || (got_aw && !got_w && wcnt == 0);
            if (r_hs) s_if.rvalid = 1'b0;
            if (ar_hs) begin rpend = 1; rcnt = r_dly; end
            else if (rcnt > 0) rcnt--;
            if (rpend && rcnt == 0) begin
               s_if.rvalid = 1'b1;
               s_if.rdata = rd_model(ar_a);
               rpend = 0;
            end
         end
      end
   end

   // Completion monitor and ownership invariants
   always @(negedge ACLK) begin
      if (ARESETn) begin
         for (int k = 0; k < 2; k++) begin
            exp_t e;
            if ((o_bvalid[k] && m_bready[k]) ||
                (o_rvalid[k] && m_rready[k])) begin
               if (sb.size() == 0) begin
                  chk("sb_unexpected", 64'(k), 64'hFF);
               end else begin
                  e = sb.pop_front();
                  chk("sb_master", 64'(k), 64'(e.mst));
                  chk("sb_grant", grant, e.mst);
                  if (e.wr) begin
                     chk("sb_kind_b", o_bvalid[k], 1);
                     chk("b_resp", o_bresp[k], 0);
                     chk("w_addr", cap_awaddr, e.addr);
                     chk("w_data", cap_wdata, e.data);
                     chk("w_strb", cap_wstrb, e.strb);
                  end else begin
                     chk("sb_kind_r", o_rvalid[k], 1);
                     chk("r_data", o_rdata[k], e.data);
                     chk("r_resp", o_rresp[k], 0);
                  end
                  exp_pri = ~e.mst;
               end
            end
            if (!busy || grant != 1'(k))
               chk("quiet_m", {o_awready[k], o_wready[k], o_bvalid[k],
                               o_arready[k], o_rvalid[k]}, 0);
         end
         if (!busy)
            chk("quiet_s", {s_if.awvalid, s_if.wvalid, s_if.bready,
                            s_if.arvalid, s_if.rready}, 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   task automatic m_write(input int m, input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          input logic [DW/8-1:0] st);
      logic aw_hs, w_hs, b_hs;
      bit b_ok = 0;
      m_awvalid[m] = 1'b1; m_awaddr[m] = a;
      m_wvalid[m] = 1'b1;  m_wdata[m] = d; m_wstrb[m] = st;
      for (int c = 0; c < 60 && !b_ok; c++) begin
         @(negedge ACLK);
         aw_hs = m_awvalid[m] && o_awready[m];
         w_hs  = m_wvalid[m] && o_wready[m];
         b_hs  = o_bvalid[m] && m_bready[m];
         @(posedge ACLK);
         #1;
         if (aw_hs) m_awvalid[m] = 1'b0;
         if (w_hs) m_wvalid[m] = 1'b0;
         if (b_hs) b_ok = 1;
      end
      m_awvalid[m] = 1'b0;
      m_wvalid[m] = 1'b0;
      chk("wr_done", b_ok, 1);
   endtask

   task automatic m_read(input int m, input logic [AW-1:0] a);
      logic ar_hs, r_hs;
      bit r_ok = 0;
      m_arvalid[m] = 1'b1; m_araddr[m] = a;
      for (int c = 0; c < 60 && !r_ok; c++) begin
         @(negedge ACLK);
         ar_hs = m_arvalid[m] && o_arready[m];
         r_hs  = o_rvalid[m] && m_rready[m];
         @(posedge ACLK);
         #1;
         if (ar_hs) m_arvalid[m] = 1'b0;
         if (r_hs) r_ok = 1;
      end
      m_arvalid[m] = 1'b0;
      chk("rd_done", r_ok, 1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      exp_t tbl[6];
      logic p;
      bit ok;
      logic [AW-1:0] ca;
      logic [DW-1:0] cd;

      tbl[0] = '{1'b1, 1'b0, 32'h20, 32'h1234_5678, 4'h0};
      tbl[1] = '{1'b0, 1'b0, 32'h44, rd_model(32'h44), 4'h0};
      tbl[2] = '{1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'h3};
      tbl[3] = '{1'b0, 1'b1, 32'hFC, 32'h0123_4567, 4'h8};
      tbl[4] = '{1'b1, 1'b0, 32'h0, 32'h1234_5658, 4'h0};
      tbl[5] = '{1'b1, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF};

      for (int k = 0; k < 2; k++) begin
         m_awvalid[k] = 0; m_awaddr[k] = '0;
         m_wvalid[k] = 0;  m_wdata[k] = '0; m_wstrb[k] = '0;
         m_arvalid[k] = 0; m_araddr[k] = '0;
         m_bready[k] = 1;  m_rready[k] = 1;
      end
      exp_pri = 1'b0;

      ARESETn = 1'b0;
      tick(3);
      @(negedge ACLK);
      chk("rst_state", {grant, busy}, 0);
      chk("rst_valids", {s_if.awvalid, s_if.wvalid, s_if.bready,
                         s_if.arvalid, s_if.rready, o_awready[0],
                         o_bvalid[1], o_rvalid[0], o_arready[1]}, 0);
      tick(1);
      ARESETn = 1'b1;
      tick(1);

      // First write: one cycle arbitration latency
      sb.push_back('{1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF});
      fork
         m_write(0, 32'h10, 32'hA5A5_A5A5, 4'hF);
         begin
            @(negedge ACLK);
            chk("lat_idle", {s_if.awvalid, s_if.wvalid, busy}, 0);
            @(negedge ACLK);
            chk("lat_fwd", {s_if.awvalid, s_if.wvalid, busy, grant},
                4'b1110);
            chk("lat_addr", s_if.awaddr, 32'h10);
         end
      join
      @(negedge ACLK);
      chk("wr_back_idle", busy, 0);
      tick(1);

      // Table-driven single transactions
      for (int i = 0; i < 6; i++) begin
         sb.push_back(tbl[i]);
         if (tbl[i].wr)
            m_write(int'(tbl[i].mst), tbl[i].addr, tbl[i].data,
                    tbl[i].strb);
         else
            m_read(int'(tbl[i].mst), tbl[i].addr);
      end

      // Both masters writing back-to-back: grants alternate
      p = exp_pri;
      for (int j = 0; j < 4; j++) begin
         logic mm;
         mm = p ^ 1'(j);
         ca = 32'h200 + 32'(mm) * 16 + 32'(j / 2) * 4;
         cd = 32'hC0DE_0000 | (32'(mm) << 8) | 32'(j / 2);
         sb.push_back('{mm, 1'b1, ca, cd, 4'hF});
      end
      fork
         begin
            m_write(0, 32'h200, 32'hC0DE_0000, 4'hF);
            m_write(0, 32'h204, 32'hC0DE_0001, 4'hF);
         end
         begin
            m_write(1, 32'h210, 32'hC0DE_0100, 4'hF);
            m_write(1, 32'h214, 32'hC0DE_0101, 4'hF);
         end
      join

      // AW without W (and W without AW) is not a request
      m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h30;
      m_wvalid[1] = 1'b1;  m_wdata[1] = 32'h1;
      repeat (3) begin
         @(negedge ACLK);
         chk("half_wr_nogrant", busy, 0);
      end
      tick(1);
      m_wvalid[1] = 1'b0;
      sb.push_back('{1'b0, 1'b1, 32'h30, 32'h3333_0000, 4'h5});
      m_write(0, 32'h30, 32'h3333_0000, 4'h5);

      // W channel lagging AW by 3 cycles
      w_dly = 1;
      sb.push_back('{1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF});
      fork
         m_write(0, 32'h40, 32'h0BAD_F00D, 4'hF);
         begin
            ok = 0;
            for (int c = 0; c < 20 && !ok; c++) begin
               @(negedge ACLK);
               ok = s_if.awvalid & s_if.awready;
            end
            chk("dly_aw_seen", ok, 1);
            @(negedge ACLK);
            chk("dly_aw_masked", {s_if.awvalid, o_awready[0]}, 0);
            repeat (3) begin
               chk("dly_wait_w", {busy, s_if.wvalid, s_if.wready,
                                  s_if.bvalid}, 4'b1100);
               @(negedge ACLK);
            end
            chk("dly_w_go", {busy, s_if.wvalid, s_if.wready}, 3'b111);
         end
      join
      tick(1);
      w_dly = 0;
      tick(1);

      // Write and read pending on one master: write goes first
      sb.push_back('{1'b0, 1'b1, 32'h50, 32'h5A5A_1234, 4'hF});
      sb.push_back('{1'b0, 1'b0, 32'h54, rd_model(32'h54), 4'h0});
      fork
         m_write(0, 32'h50, 32'h5A5A_1234, 4'hF);
         m_read(0, 32'h54);
      join

      // Reset in the middle of RDATA
      r_dly = 20;
      m_arvalid[1] = 1'b1; m_araddr[1] = 32'h60;
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge ACLK);
         ok = o_arready[1];
         @(posedge ACLK);
         #1;
      end
      m_arvalid[1] = 1'b0;
      chk("mid_ar_seen", ok, 1);
      @(negedge ACLK);
      chk("mid_rdata", {busy, grant, o_rvalid[1]}, 3'b110);
      tick(1);
      ARESETn = 1'b0;
      @(negedge ACLK);
      chk("mid_rst_quiet", {s_if.awvalid, s_if.wvalid, s_if.bready,
                            s_if.arvalid, s_if.rready, o_arready[1],
                            o_rvalid[1], o_rvalid[0]}, 0);
      tick(1);
      ARESETn = 1'b1;
      r_dly = 0;
      exp_pri = 1'b0;
      @(negedge ACLK);
      chk("mid_rst_state", {busy, grant}, 0);
      tick(1);

      // Pointer back at 0: m0 wins a simultaneous request
      sb.push_back('{1'b0, 1'b0, 32'h70, rd_model(32'h70), 4'h0});
      sb.push_back('{1'b1, 1'b0, 32'h74, rd_model(32'h74), 4'h0});
      fork
         m_read(0, 32'h70);
         m_read(1, 32'h74);
      join
      sb.push_back('{1'b1, 1'b0, 32'h20, 32'h1234_5678, 4'h0});
      m_read(1, 32'h20);

      tick(3);
      chk("sb_drained", 64'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/axil_rr_arbiter.md
# axil_rr_arbiter

Two-master to one-slave AXI4-Lite arbiter placed in front of the existing AXI4-Lite slave block, so two requesters (e.g. CPU port and DMA port) share its read and write channels. Grants one complete transaction (write: AW+W+B, or read: AR+R) at a time, round-robin between masters, write-before-read within a master. All routing is steered by a registered grant; no channel is ever open to the non-granted master.

## Interface
- ADDR_W, 32, address width of AW/AR
- DATA_W, 32, data width of W/R; strobe width DATA_W/8
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  synchronous, active-low reset
- m0_/m1_awvalid, m0_/m1_awaddr  in  1, ADDR_W  master write address
- m0_/m1_awready  out  1
- m0_/m1_wvalid, m0_/m1_wdata, m0_/m1_wstrb  in  1, DATA_W, DATA_W/8  master write data
- m0_/m1_wready  out  1
- m0_/m1_bvalid, m0_/m1_bresp  out  1, 2  master write response
- m0_/m1_bready  in  1
- m0_/m1_arvalid, m0_/m1_araddr  in  1, ADDR_W  master read address
- m0_/m1_arready  out  1
- m0_/m1_rvalid, m0_/m1_rdata, m0_/m1_rresp  out  1, DATA_W, 2  master read data
- m0_/m1_rready  in  1
- s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready, s_arvalid, s_araddr, s_rready  out  as above  to slave
- s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp  in  as above  from slave
- grant  out  1  registered; master currently owning the slave
- busy  out  1  high in any state other than IDLE

## Operation
- Request: wreq_i = mi_awvalid & mi_wvalid; rreq_i = mi_arvalid; req_i = wreq_i | rreq_i.
- Priority pointer pri (1 bit). In IDLE: if req_pri, grant <= pri; else if req of other master, grant <= other. Selected master: wreq -> WADDR, else RADDR.
- States: IDLE, WADDR, WRESP, RADDR, RDATA.
- WADDR: forward granted master's AW and W to slave, return s_awready/s_wready. Flags aw_done/w_done set on each handshake; after a channel's handshake its forwarded valid is masked to 0. When both done (same or different cycles) -> WRESP.
- WRESP: s_bvalid/s_bresp routed to granted master, its bready to s_bready. On B handshake -> IDLE, pri <= ~grant, flags cleared.
- RADDR: forward AR; on s_arvalid & s_arready -> RDATA.
- RDATA: route R; on R handshake -> IDLE, pri <= ~grant.
- Non-granted master, and all masters in IDLE: every ready and valid output 0. Slave-side outputs 0 in IDLE and for channels not in the current state.
- Payload (addr/data/strb/resp) muxed by grant; value don't-care when corresponding valid is 0.

## Timing
- Reset: state IDLE, pri 0, grant 0, busy 0, aw_done/w_done 0; all *valid and *ready outputs 0. Reset mid-transaction abandons it and returns to IDLE next edge; slave-side valids drop immediately.
- Request sampled in IDLE at edge n -> slave-side valid asserted in cycle n+1 (one cycle arbitration latency).
- Minimum write: IDLE, WADDR, WRESP = 3 cycles; minimum read: IDLE, RADDR, RDATA = 3 cycles; one IDLE cycle between consecutive grants.
- Master valid must stay high until its ready; arbiter never deasserts a forwarded valid before handshake except on reset.
- Simultaneous req from both masters: pri wins; alternates every transaction under continuous load.
- Write and read pending on same master: write first; read arbitrated later per pointer.
- Only AW valid without W (or vice versa): not a write request; no grant until both present.

## Test plan
- Reset then m0 write addr 0x10, data 0xA5A5A5A5, strb 0xF, slave ready -> s_awvalid/s_wvalid high cycle after request, m0_bvalid with bresp 0, grant 0, back to IDLE, pri 1.
- m1 read addr 0x20, slave returns 0x12345678 -> m1_rvalid/m1_rdata 0x12345678; m0 outputs all 0 throughout.
- Both masters issue continuous writes for 4 transactions -> grant sequence 0,1,0,1.
- Slave delays s_wready 3 cycles after s_awready -> s_awvalid drops after AW handshake, state stays WADDR until W handshake, then single B.
- m0 holds write and read simultaneously -> write completes before its read is granted.
- ARESETn low during RDATA -> next cycle all valids/readies 0, busy 0, grant 0, pri 0; new m1 read proceeds normally.
